// File: rtl/scan_llr_bank_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : scan_pkg
// Description : Shared types and helpers for the double-banked channel-LLR
//               store of the SCAN polar decoder. Holds the per-bank state
//               encoding, a constant-safe clog2, and the saturating narrow
//               used on every incoming channel lane.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

  // Per-bank lifecycle. The encoding is fixed so the state can be probed.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_LOADING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DECODING = 2'd3
  } bank_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a sign-extended channel LLR into the signed range of a q-bit word.
  // The caller keeps the low q bits of the result. When the input is already
  // q bits wide it is always in range, so the value passes through unchanged.
  function automatic logic signed [31:0] sat_llr(input logic signed [31:0] x,
                                                 input int q);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (q - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (q - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_llr_bank_buf_bank.sv
`default_nettype none
// ============================================================================
// Module      : scan_llr_bank
// Description : One frame bank of the channel-LLR store: D words of W bits,
//               one write port and two independent read ports. Each read
//               port has an output register that loads on re and otherwise
//               holds, so the last read word stays visible.
// Ports       : clk, rst (async, active-low)
//               we/waddr/wdata       - write port
//               re/raddr_l/raddr_r   - shared read strobe, two addresses
//               rdata_l/rdata_r      - registered read data (reset to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_llr_bank #(
  parameter int D  = 64,
  parameter int W  = 96,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr_l,
  input  logic [AW-1:0] raddr_r,
  output logic [W-1:0]  rdata_l,
  output logic [W-1:0]  rdata_r
);

  // Storage array is not reset; its contents are meaningless until written.
  logic [W-1:0] mem [D];

  logic [W-1:0] rdata_l_q, rdata_l_d;
  logic [W-1:0] rdata_r_q, rdata_r_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_l_d = rdata_l_q;
    rdata_r_d = rdata_r_q;
    if (re) begin
      rdata_l_d = mem[raddr_l];
      rdata_r_d = mem[raddr_r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_l_q <= '0;
      rdata_r_q <= '0;
    end else begin
      rdata_l_q <= rdata_l_d;
      rdata_r_q <= rdata_r_d;
    end
  end

  assign rdata_l = rdata_l_q;
  assign rdata_r = rdata_r_q;

endmodule
`default_nettype wire

// File: rtl/scan_llr_bank_buf.sv
`default_nettype none
// ============================================================================
// Module      : scan_llr_bank_buf
// Description : Double-banked channel-LLR store. Frame k+1 is loaded over a
//               valid/ready stream (saturated QIN->Q per lane) while frame k
//               is read by the decoder through two P-lane ports.
// Ports       : clk, rst (async, active-low)
//               ch_valid/ch_ready/ch_data/ch_last - channel LLR stream
//               frame_valid/frame_take/frame_done - frame handshake
//               dec_active                        - bank at dp is decoding
//               rd_en/rd_addr_l/rd_addr_r         - read request
//               alpha_l/alpha_r                   - read data, 1-cycle latency
//               err_len                           - sticky frame-length error
// Revision    : 1.0 - initial release
// ============================================================================
module scan_llr_bank_buf
  import scan_pkg::*;
#(
  parameter  int N   = 1024,
  parameter  int P   = 16,
  parameter  int Q   = 6,
  parameter  int QIN = 8,
  localparam int D   = N / P,
  localparam int AW  = clog2(D)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_valid,
  output logic             ch_ready,
  input  logic [P*QIN-1:0] ch_data,
  input  logic             ch_last,
  output logic             frame_valid,
  input  logic             frame_take,
  input  logic             frame_done,
  output logic             dec_active,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_l,
  input  logic [AW-1:0]    rd_addr_r,
  output logic [P*Q-1:0]   alpha_l,
  output logic [P*Q-1:0]   alpha_r,
  output logic             err_len
);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          lp_q, lp_d;
  logic          dp_q, dp_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          err_len_q, err_len_d;
  // Bank that produced the word currently held on the read registers.
  logic          rd_sel_q, rd_sel_d;

  logic           w_accept;
  logic           w_done;
  logic           w_take;
  logic           w_rd_fire;
  logic [P*Q-1:0] w_wdata;
  logic [P*Q-1:0] w_bank_l [2];
  logic [P*Q-1:0] w_bank_r [2];

  assign ch_ready    = (state_q[lp_q] == BANK_EMPTY) || (state_q[lp_q] == BANK_LOADING);
  assign frame_valid = (state_q[dp_q] == BANK_FULL);
  assign dec_active  = (state_q[dp_q] == BANK_DECODING);
  assign err_len     = err_len_q;

  assign w_accept  = ch_valid && ch_ready;
  assign w_done    = frame_done && dec_active;
  // A done in the same cycle wins; the take is dropped, not deferred.
  assign w_take    = frame_take && frame_valid && !w_done;
  assign w_rd_fire = rd_en && dec_active;

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic signed [31:0] w_ext;
    assign w_ext = 32'(signed'(ch_data[l*QIN +: QIN]));
    assign w_wdata[l*Q +: Q] = Q'(sat_llr(w_ext, Q));
  end

  // The load side only touches bank lp (EMPTY/LOADING) and the decode side
  // only bank dp (FULL/DECODING), so both updates can land in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) state_d[b] = state_q[b];
    lp_d      = lp_q;
    dp_d      = dp_q;
    wcnt_d    = wcnt_q;
    err_len_d = err_len_q;
    rd_sel_d  = w_rd_fire ? dp_q : rd_sel_q;

    if (w_done) begin
      state_d[dp_q] = BANK_EMPTY;
      dp_d          = ~dp_q;
    end else if (w_take) begin
      state_d[dp_q] = BANK_DECODING;
    end

    if (w_accept) begin
      if (wcnt_q == AW'(D - 1)) begin
        // A full-length frame is kept even if ch_last was missing.
        state_d[lp_q] = BANK_FULL;
        wcnt_d        = '0;
        lp_d          = ~lp_q;
        if (!ch_last) err_len_d = 1'b1;
      end else if (ch_last) begin
        // Short frame: drop it and refill the same bank from word 0.
        state_d[lp_q] = BANK_EMPTY;
        wcnt_d        = '0;
        err_len_d     = 1'b1;
      end else begin
        state_d[lp_q] = BANK_LOADING;
        wcnt_d        = wcnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      lp_q       <= 1'b0;
      dp_q       <= 1'b0;
      wcnt_q     <= '0;
      err_len_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      lp_q       <= lp_d;
      dp_q       <= dp_d;
      wcnt_q     <= wcnt_d;
      err_len_q  <= err_len_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    scan_llr_bank #(
      .D  (D),
      .W  (P * Q),
      .AW (AW)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (w_accept && (lp_q == 1'(b))),
      .waddr   (wcnt_q),
      .wdata   (w_wdata),
      .re      (w_rd_fire && (dp_q == 1'(b))),
      .raddr_l (rd_addr_l),
      .raddr_r (rd_addr_r),
      .rdata_l (w_bank_l[b]),
      .rdata_r (w_bank_r[b])
    );
  end

  // Both bank read registers hold between reads and rd_sel_q only moves on a
  // read, so the selected output holds as well and resets to zero.
  assign alpha_l = w_bank_l[rd_sel_q];
  assign alpha_r = w_bank_r[rd_sel_q];

endmodule
`default_nettype wire

// File: tb/tb_scan_llr_bank_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_llr_bank_buf
// Description : Directed self-checking bench for scan_llr_bank_buf with
//               N=1024, P=16, Q=6, QIN=8 (64 words per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_llr_bank_buf;

  localparam int N   = 1024;
  localparam int P   = 16;
  localparam int Q   = 6;
  localparam int QIN = 8;
  localparam int D   = 64;
  localparam int AW  = 6;

  logic             clk;
  logic             rst;
  logic             ch_valid;
  logic             ch_ready;
  logic [P*QIN-1:0] ch_data;
  logic             ch_last;
  logic             frame_valid;
  logic             frame_take;
  logic             frame_done;
  logic             dec_active;
  logic             rd_en;
  logic [AW-1:0]    rd_addr_l;
  logic [AW-1:0]    rd_addr_r;
  logic [P*Q-1:0]   alpha_l;
  logic [P*Q-1:0]   alpha_r;
  logic             err_len;

  int checks = 0;
  int errors = 0;
  int stalls;

  logic [P*QIN-1:0] sat_in;
  logic [P*Q-1:0]   sat_exp;

  scan_llr_bank_buf #(
    .N   (N),
    .P   (P),
    .Q   (Q),
    .QIN (QIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_data     (ch_data),
    .ch_last     (ch_last),
    .frame_valid (frame_valid),
    .frame_take  (frame_take),
    .frame_done  (frame_done),
    .dec_active  (dec_active),
    .rd_en       (rd_en),
    .rd_addr_l   (rd_addr_l),
    .rd_addr_r   (rd_addr_r),
    .alpha_l     (alpha_l),
    .alpha_r     (alpha_r),
    .err_len     (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Every lane carries the same 8-bit channel value.
  function automatic logic [P*QIN-1:0] rep8(input int v);
    logic [P*QIN-1:0] r;
    for (int l = 0; l < P; l++) r[l*QIN +: QIN] = 8'(v);
    return r;
  endfunction

  // Every lane carries the same 6-bit stored value (v must be in -32..31).
  function automatic logic [P*Q-1:0] rep6(input int v);
    logic [P*Q-1:0] r;
    for (int l = 0; l < P; l++) r[l*Q +: Q] = 6'(v);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int al, input int ar);
    rd_en     = 1'b1;
    rd_addr_l = AW'(al);
    rd_addr_r = AW'(ar);
    tick();
    rd_en     = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    ch_valid   = 1'b0;
    ch_data    = '0;
    ch_last    = 1'b0;
    frame_take = 1'b0;
    frame_done = 1'b0;
    rd_en      = 1'b0;
    rd_addr_l  = '0;
    rd_addr_r  = '0;

    sat_in          = '0;
    sat_in[7:0]     = 8'h64;   // +100
    sat_in[15:8]    = 8'h9C;   // -100
    sat_in[23:16]   = 8'h1F;   // +31
    sat_in[31:24]   = 8'hE0;   // -32
    sat_in[39:32]   = 8'hFF;   // -1
    sat_exp         = '0;
    sat_exp[5:0]    = 6'h1F;   // +31
    sat_exp[11:6]   = 6'h20;   // -32
    sat_exp[17:12]  = 6'h1F;   // +31
    sat_exp[23:18]  = 6'h20;   // -32
    sat_exp[29:24]  = 6'h3F;   // -1

    // ---------------- reset values ----------------
    tick();
    tick();
    check("rst_ch_ready", ch_ready, 1);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_dec_active", dec_active, 0);
    check("rst_alpha_l", alpha_l, 0);
    check("rst_alpha_r", alpha_r, 0);
    check("rst_err_len", err_len, 0);
    rst = 1'b1;
    tick();

    // ---------------- frame A: lane value = word index ----------------
    stalls = 0;
    for (int i = 0; i < D; i++) begin
      ch_valid = 1'b1;
      ch_data  = rep8(i);
      ch_last  = (i == D - 1);
      if (!ch_ready) stalls++;
      if (i == D - 1) check("a_fv_before_last", frame_valid, 0);
      tick();
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    check("a_stalls", 128'(stalls), 0);
    check("a_fv_after_last", frame_valid, 1);
    check("a_err_len", err_len, 0);
    check("a_ch_ready_bank1", ch_ready, 1);

    frame_take = 1'b1;
    tick();
    frame_take = 1'b0;
    check("a_take_dec_active", dec_active, 1);
    check("a_take_fv_low", frame_valid, 0);

    // Word 63 holds channel value 63, which clamps to +31 in 6 bits.
    do_read(5, 63);
    check("a_rd_l5", alpha_l, rep6(5));
    check("a_rd_r63", alpha_r, rep6(31));
    do_read(17, 17);
    check("a_rd_same_l", alpha_l, rep6(17));
    check("a_rd_same_r", alpha_r, rep6(17));
    rd_addr_l = 6'd0;
    rd_addr_r = 6'd1;
    tick();
    check("a_rd_hold_l", alpha_l, rep6(17));
    check("a_rd_hold_r", alpha_r, rep6(17));

    // ---------------- frame B loads while A decodes ----------------
    // Word 0 carries the saturation pattern, word i>0 carries i-32.
    stalls = 0;
    for (int i = 0; i < D; i++) begin
      ch_valid = 1'b1;
      ch_data  = (i == 0) ? sat_in : rep8(i - 32);
      ch_last  = (i == D - 1);
      if (!ch_ready) stalls++;
      tick();
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    check("b_stalls", 128'(stalls), 0);
    check("b_both_busy_ready", ch_ready, 0);
    check("b_fv_dp_decoding", frame_valid, 0);
    check("b_dec_active", dec_active, 1);

    // Frame C waits for a free bank.
    ch_valid = 1'b1;
    ch_data  = rep8(9);
    repeat (3) tick();
    check("c_blocked", ch_ready, 0);
    frame_done = 1'b1;
    check("c_blocked_at_done", ch_ready, 0);
    tick();
    frame_done = 1'b0;
    ch_valid   = 1'b0;
    check("c_ready_after_done", ch_ready, 1);
    check("b_fv_after_done", frame_valid, 1);
    check("b_dec_idle", dec_active, 0);

    frame_take = 1'b1;
    tick();
    frame_take = 1'b0;
    check("b_take_dec_active", dec_active, 1);
    do_read(0, 1);
    check("b_sat_lanes", alpha_l, sat_exp);
    check("b_rd_r1", alpha_r, rep6(-31));
    do_read(50, 63);
    check("b_rd_l50", alpha_l, rep6(18));
    check("b_rd_r63", alpha_r, rep6(31));
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("b_done_fv", frame_valid, 0);
    check("b_done_dec", dec_active, 0);
    check("b_done_ready", ch_ready, 1);

    // ---------------- early ch_last on beat 10 ----------------
    for (int i = 0; i <= 10; i++) begin
      ch_valid = 1'b1;
      ch_data  = rep8(5);
      ch_last  = (i == 10);
      tick();
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    check("early_err_len", err_len, 1);
    check("early_fv", frame_valid, 0);
    check("early_ready", ch_ready, 1);

    for (int i = 0; i < D; i++) begin
      ch_valid = 1'b1;
      ch_data  = rep8(i - 32);
      ch_last  = (i == D - 1);
      tick();
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    check("early_reload_fv", frame_valid, 1);
    frame_take = 1'b1;
    tick();
    frame_take = 1'b0;
    do_read(3, 10);
    check("early_reload_l3", alpha_l, rep6(-29));
    check("early_reload_r10", alpha_r, rep6(-22));

    // ---------------- async reset mid-decode, other bank FULL ----------------
    for (int i = 0; i < D; i++) begin
      ch_valid = 1'b1;
      ch_data  = rep8(3);
      ch_last  = (i == D - 1);
      tick();
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    check("pre_rst_ready", ch_ready, 0);
    check("pre_rst_err", err_len, 1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_ch_ready", ch_ready, 1);
    check("arst_frame_valid", frame_valid, 0);
    check("arst_dec_active", dec_active, 0);
    check("arst_alpha_l", alpha_l, 0);
    check("arst_alpha_r", alpha_r, 0);
    check("arst_err_len", err_len, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_fv", frame_valid, 0);
    check("post_rst_ready", ch_ready, 1);

    // ---------------- 64 beats without ch_last ----------------
    for (int i = 0; i < D; i++) begin
      ch_valid = 1'b1;
      ch_data  = rep8(1);
      ch_last  = 1'b0;
      if (i == D - 1) check("nolast_err_before", err_len, 0);
      tick();
    end
    ch_valid = 1'b0;
    check("nolast_fv", frame_valid, 1);
    check("nolast_err_len", err_len, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
